// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// A request is checked and latched in IDLE, held for LATENCY cycles in WAIT,
// and then performed on an internal word array. Done and AddrError are
// registered one-cycle pulses. Busy is decoded from the state register.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        Done,
  output logic        Busy,
  output logic        AddrError
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_write_q, op_write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mem_we;

  logic [63:0]        mem [DEPTH_WORDS];

  logic               req;
  logic               misaligned;
  logic               out_of_range;
  logic               conflict;

  assign req          = MemoryRead | MemoryWrite;
  assign misaligned   = (Address[2:0] != 3'b000);
  assign out_of_range = (Address >= (64'(DEPTH_WORDS) * 64'd8));
  assign conflict     = MemoryRead & MemoryWrite;

  // Control and result registers; reset returns to IDLE and clears outputs at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept or reject in IDLE, count down and complete in WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned || out_of_range || conflict) begin
            err_d = 1'b1;
          end else begin
            state_d    = WAIT;
            cnt_d      = CNT_W'(LATENCY - 1);
            op_write_d = MemoryWrite;
            idx_d      = Address[3 +: IDX_W];
            wdata_d    = WriteData;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (op_write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word array; never reset, so an access discarded by reset leaves it untouched.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ReadData  = rdata_q;
  assign Done      = done_q;
  assign AddrError = err_q;
  assign Busy      = (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the functional
// sequence, LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        Clk;
  logic        Rst;

  logic        MemoryRead, MemoryWrite;
  logic [63:0] Address, WriteData, ReadData;
  logic        Done, Busy, AddrError;

  logic        MemoryRead1, MemoryWrite1;
  logic [63:0] Address1, WriteData1, ReadData1;
  logic        Done1, Busy1, AddrError1;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Done(Done), .Busy(Busy), .AddrError(AddrError)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .Clk(Clk), .Rst(Rst),
    .MemoryRead(MemoryRead1), .MemoryWrite(MemoryWrite1),
    .Address(Address1), .WriteData(WriteData1),
    .ReadData(ReadData1), .Done(Done1), .Busy(Busy1), .AddrError(AddrError1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // LATENCY=2 transfer with timing checks; returns in the Done cycle.
  task automatic xfer(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                      input string tag);
    MemoryRead  = ~wr;
    MemoryWrite = wr;
    Address     = addr;
    WriteData   = data;
    step();
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b0;
    chk({tag, " busy c1"}, 64'(Busy), 64'd1);
    chk({tag, " done c1"}, 64'(Done), 64'd0);
    step();
    chk({tag, " busy c2"}, 64'(Busy), 64'd1);
    chk({tag, " done c2"}, 64'(Done), 64'd0);
    step();
    chk({tag, " busy c3"}, 64'(Busy), 64'd0);
    chk({tag, " done c3"}, 64'(Done), 64'd1);
  endtask

  // Rejected request: AddrError pulse, no Busy, no Done.
  task automatic reject(input logic rd, input logic wr, input logic [63:0] addr, input string tag);
    MemoryRead  = rd;
    MemoryWrite = wr;
    Address     = addr;
    WriteData   = 64'hBAD0BAD0BAD0BAD0;
    step();
    MemoryRead  = 1'b0;
    MemoryWrite = 1'b0;
    chk({tag, " err"},   64'(AddrError), 64'd1);
    chk({tag, " busy"},  64'(Busy), 64'd0);
    chk({tag, " done"},  64'(Done), 64'd0);
    step();
    chk({tag, " err off"},  64'(AddrError), 64'd0);
    chk({tag, " busy off"}, 64'(Busy), 64'd0);
    chk({tag, " done off"}, 64'(Done), 64'd0);
  endtask

  initial begin
    Rst = 1'b0;
    MemoryRead = 1'b0; MemoryWrite = 1'b0; Address = '0; WriteData = '0;
    MemoryRead1 = 1'b0; MemoryWrite1 = 1'b0; Address1 = '0; WriteData1 = '0;

    // Asynchronous reset before any clock edge
    #2 Rst = 1'b1;
    #1;
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst done", 64'(Done), 64'd0);
    chk("rst err",  64'(AddrError), 64'd0);
    chk("rst rdata", ReadData, 64'd0);
    step();
    Rst = 1'b0;
    step();

    // Write then read
    xfer(1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, "wr10");
    step();
    chk("wr10 done pulse", 64'(Done), 64'd0);
    xfer(1'b0, 64'h10, 64'h0, "rd10");
    chk("rd10 data", ReadData, 64'hDEADBEEFCAFEF00D);
    step();
    chk("rd10 data held", ReadData, 64'hDEADBEEFCAFEF00D);

    // Seed words used later
    xfer(1'b1, 64'h08, 64'h0808, "wr08");
    xfer(1'b1, 64'h28, 64'h2828, "wr28");
    xfer(1'b1, 64'h18, 64'hAAAA, "wr18");
    step();

    // Rejections
    reject(1'b1, 1'b0, 64'h0C,  "misaligned");
    reject(1'b1, 1'b0, 64'h200, "range");
    reject(1'b1, 1'b1, 64'h08,  "both");
    xfer(1'b0, 64'h08, 64'h0, "rd08");
    chk("rd08 unchanged", ReadData, 64'h0808);

    // Inputs ignored while busy
    MemoryWrite = 1'b1; Address = 64'h20; WriteData = 64'h1111;
    step();
    chk("stab busy", 64'(Busy), 64'd1);
    Address = 64'h28; WriteData = 64'h2222;
    step();
    MemoryWrite = 1'b0;
    step();
    chk("stab done", 64'(Done), 64'd1);
    xfer(1'b0, 64'h20, 64'h0, "rd20");
    chk("rd20 data", ReadData, 64'h1111);
    xfer(1'b0, 64'h28, 64'h0, "rd28");
    chk("rd28 data", ReadData, 64'h2828);
    step();

    // Reset during an in-flight write
    MemoryWrite = 1'b1; Address = 64'h18; WriteData = 64'h5555;
    step();
    MemoryWrite = 1'b0;
    chk("rstw busy", 64'(Busy), 64'd1);
    step();
    #2 Rst = 1'b1;
    #1;
    chk("rstw busy async",  64'(Busy), 64'd0);
    chk("rstw done async",  64'(Done), 64'd0);
    chk("rstw err async",   64'(AddrError), 64'd0);
    chk("rstw rdata async", ReadData, 64'd0);
    step();
    chk("rstw done held", 64'(Done), 64'd0);
    Rst = 1'b0;
    step();
    chk("rstw no done", 64'(Done), 64'd0);
    chk("rstw idle", 64'(Busy), 64'd0);
    xfer(1'b0, 64'h18, 64'h0, "rd18");
    chk("rd18 unchanged", ReadData, 64'hAAAA);

    // LATENCY=1 back-to-back writes with a held request
    MemoryWrite1 = 1'b1; Address1 = 64'h30; WriteData1 = 64'h3030;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b2b busy", 64'(Busy1), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("b2b done", 64'(Done1), (i % 2 == 1) ? 64'd1 : 64'd0);
      chk("b2b exclusive", 64'(Busy1 & Done1), 64'd0);
    end
    MemoryWrite1 = 1'b0; MemoryRead1 = 1'b1;
    step();
    MemoryRead1 = 1'b0;
    chk("b2b rd busy", 64'(Busy1), 64'd1);
    step();
    chk("b2b rd done", 64'(Done1), 64'd1);
    chk("b2b rd data", ReadData1, 64'h3030);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle responder for the data-memory side of the pipeline's MEM stage. It accepts whole-word (64-bit) load/store requests presented on `MemoryRead`/`MemoryWrite`/`Address`/`WriteData`. It holds the request for a configurable latency, then performs the access on an internal word array. Completion is reported with a one-cycle `Done` pulse, and read data is returned on `ReadData`. It replaces the zero-latency data memory when the pipeline is run against slow-memory timing, and supplies `Busy` for the stall logic.

## Interface
- `DEPTH_WORDS`, default 64: number of 64-bit words; power of two, ≥2.
- `LATENCY`, default 2: cycles from accept edge to completion edge; ≥1.
- `Clk` in 1: rising-edge clock.
- `Rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `MemoryRead` in 1: load request.
- `MemoryWrite` in 1: store request.
- `Address` in 64: byte address; must be 8-byte aligned.
- `WriteData` in 64: store data.
- `ReadData` out 64: load result; held until the next read completion or reset.
- `Done` out 1: one-cycle pulse, access completed (read or write).
- `Busy` out 1: a request is in flight; new requests are ignored.
- `AddrError` out 1: one-cycle pulse, request rejected.

## Operation
- States:
  - IDLE: `Busy`=0.
  - WAIT: `Busy`=1. Holds a down-counter, latched op, word index, and data.
- Request present = `MemoryRead` | `MemoryWrite`. Sampled only at a rising edge where `Busy`=0.
- Rejection at the sampling edge. The request is rejected if either of these holds:
  - `Address[2:0]`≠0, or `Address` ≥ DEPTH_WORDS*8.
  - Both `MemoryRead` and `MemoryWrite` are 1.
- On rejection: `AddrError`=1 for the following cycle. State stays IDLE, the array is unchanged, and no `Done` is produced.
- Accept (valid request in IDLE):
  - Latch op, word index `Address[3+log2(DEPTH_WORDS)-1:3]`, and `WriteData`.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Each edge decrements the counter.
  - At the edge where the counter is 0, perform the access:
    - Write: array[index] ← latched data.
    - Read: `ReadData` ← array[index].
  - Pulse `Done`=1 and return to IDLE.
- Inputs are ignored while `Busy`=1. Changing `WriteData` or `Address` during WAIT has no effect.
- The requester deasserts `MemoryRead`/`MemoryWrite` no later than the `Done` cycle. A request still present at the next edge is treated as a new request.
- Array contents are not cleared by reset. Reading an unwritten word returns an undefined value; benches write before reading.

## Timing
- Accept at edge E0. Then:
  - `Busy`=1 during the cycles between E0 and E_LATENCY.
  - The access executes at E_LATENCY.
  - `Done`=1 and `Busy`=0 in the cycle after E_LATENCY.
- Read data is valid in the `Done` cycle and held afterwards.
- Next accept is possible at E_LATENCY+1. Peak throughput is one access per LATENCY+1 cycles.
- `AddrError` is asserted in the cycle after the rejecting edge. It never coincides with `Busy`=1.
- `Done` and `AddrError` are registered outputs. `Busy` is derived from the state register.
- Reset (asynchronous, any time):
  - Immediately: state=IDLE, `Busy`=0, `Done`=0, `AddrError`=0, `ReadData`=0.
  - An in-flight write is discarded and the array is unchanged.
  - An in-flight read produces no `Done`.
- First sampling edge: the first rising edge after `Rst` falls.

## Test plan
- Reset: assert `Rst` mid-cycle → `Busy`=0, `Done`=0, `AddrError`=0, `ReadData`=0 asynchronously, before the next edge.
- Write then read (LATENCY=2):
  - Write 0xDEADBEEFCAFEF00D to 0x10 → `Busy` high 2 cycles, `Done` pulse on the 3rd cycle after accept.
  - Read 0x10 → `Done` with `ReadData`=0xDEADBEEFCAFEF00D.
- Rejections, each giving `AddrError` pulse, `Busy` staying 0, and no `Done`:
  - Read 0x0C (misaligned).
  - Read 0x200 (= DEPTH_WORDS*8, out of range).
  - Read and write both asserted at 0x08. A later read of 0x08 returns the prior value.
- Input stability during WAIT:
  - Write 0x1111 to 0x20, then change `WriteData` to 0x2222 and `Address` to 0x28 while `Busy`=1.
  - Read 0x20 → 0x1111. Read 0x28 → its prior value.
- Reset mid-write:
  - Write 0x5555 to 0x18, where 0x18 previously held 0xAAAA. Assert `Rst` one cycle after accept.
  - No `Done` is produced. A read of 0x18 returns 0xAAAA.
- LATENCY=1, back-to-back:
  - Hold `MemoryWrite` continuously with stable inputs → accepts every 2nd edge.
  - `Done` pulses on alternate cycles. `Busy` and `Done` are never both 1.
